updown_mod_counter: RTL and testbench



---
 rtl/updown_mod_counter.sv | 131 +++++++++++++
 tb/tb_updown_mod_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - modulo MAX+1 up/down counter with lockstep BCD digits
module updown_mod_counter #(
    parameter int WIDTH   = 8,
    parameter int MAX     = 99,
    parameter int NDIGITS = 2
) (
    input  logic                   clk_1Hz,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   updown,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_val,
    output logic [WIDTH-1:0]       count,
    output logic [4*NDIGITS-1:0]   bcd,
    output logic                   wrap,
    output logic                   at_term
);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Binary to BCD by repeated division; only used for load values and constants.
    function automatic logic [4*NDIGITS-1:0] to_bcd(input logic [WIDTH-1:0] val);
        logic [4*NDIGITS-1:0] r;
        int unsigned          v;
        r = '0;
        v = 32'(val);
        for (int i = 0; i < NDIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    localparam longint unsigned BIN_SPAN = 64'd1 << WIDTH;
    localparam longint unsigned DEC_SPAN = pow10(NDIGITS);
    localparam longint unsigned MAX_L    = 64'(MAX);

    if (MAX < 1 || BIN_SPAN <= MAX_L || DEC_SPAN <= MAX_L) begin : g_param_check
        $error("updown_mod_counter: MAX must be >= 1 and representable in WIDTH bits and NDIGITS digits");
    end

    localparam logic [WIDTH-1:0]     MAX_W   = WIDTH'(MAX);
    localparam logic [4*NDIGITS-1:0] BCD_MAX = to_bcd(MAX_W);

    logic [WIDTH-1:0]     load_sat;
    logic [4*NDIGITS-1:0] load_bcd;
    logic [4*NDIGITS-1:0] bcd_inc;
    logic [4*NDIGITS-1:0] bcd_dec;
    logic                 carry;
    logic                 borrow;

    assign load_sat = (load_val > MAX_W) ? MAX_W : load_val;
    assign load_bcd = to_bcd(load_sat);
    assign at_term  = updown ? (count == MAX_W) : (count == '0);

    // Per-digit ripple +1 / -1 of the current BCD value (9->0 carries, 0->9 borrows).
    always_comb begin
        bcd_inc = bcd;
        bcd_dec = bcd;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (carry) begin
                if (bcd[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (bcd[4*i +: 4] == 4'd0) begin
                    bcd_dec[4*i +: 4] = 4'd9;
                end else begin
                    bcd_dec[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Count, BCD and wrap state: reset > load > enabled step > hold.
    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            wrap <= 1'b0;
            if (updown) begin
                count <= '0;
                bcd   <= '0;
            end else begin
                count <= MAX_W;
                bcd   <= BCD_MAX;
            end
        end else if (load) begin
            count <= load_sat;
            bcd   <= load_bcd;
            wrap  <= 1'b0;
        end else if (en) begin
            if (updown) begin
                if (count == MAX_W) begin
                    count <= '0;
                    bcd   <= '0;
                    wrap  <= 1'b1;
                end else begin
                    count <= count + WIDTH'(1);
                    bcd   <= bcd_inc;
                    wrap  <= 1'b0;
                end
            end else begin
                if (count == '0) begin
                    count <= MAX_W;
                    bcd   <= BCD_MAX;
                    wrap  <= 1'b1;
                end else begin
                    count <= count - WIDTH'(1);
                    bcd   <= bcd_dec;
                    wrap  <= 1'b0;
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - self-checking bench for updown_mod_counter
module tb_updown_mod_counter;

    typedef struct packed {
        int c;
        bit w;
    } st_t;

    logic       clk;
    int         vectors     = 0;
    int         miscompares = 0;
    bit         chk         = 0;

    logic       reset_a, en_a, ud_a, load_a;
    logic [7:0] load_val_a, count_a, bcd_a;
    logic       wrap_a, at_term_a;

    logic       reset_b, en_b, ud_b, load_b;
    logic [5:0] load_val_b, count_b;
    logic [7:0] bcd_b;
    logic       wrap_b, at_term_b;

    st_t ma = '0;
    st_t mb = '0;

    updown_mod_counter #(.WIDTH(8), .MAX(99), .NDIGITS(2)) dut_a (
        .clk_1Hz(clk), .reset(reset_a), .en(en_a), .updown(ud_a), .load(load_a),
        .load_val(load_val_a), .count(count_a), .bcd(bcd_a), .wrap(wrap_a), .at_term(at_term_a)
    );

    updown_mod_counter #(.WIDTH(6), .MAX(59), .NDIGITS(2)) dut_b (
        .clk_1Hz(clk), .reset(reset_b), .en(en_b), .updown(ud_b), .load(load_b),
        .load_val(load_val_b), .count(count_b), .bcd(bcd_b), .wrap(wrap_b), .at_term(at_term_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic st_t nxt(input int mx, input st_t s, input bit rst, input bit ld,
                                input bit e, input bit ud, input int lv);
        st_t r;
        r = s;
        r.w = 1'b0;
        if (rst)     r.c = ud ? 0 : mx;
        else if (ld) r.c = (lv > mx) ? mx : lv;
        else if (e) begin
            if (ud) begin
                if (s.c == mx) begin r.c = 0; r.w = 1'b1; end
                else r.c = s.c + 1;
            end else begin
                if (s.c == 0) begin r.c = mx; r.w = 1'b1; end
                else r.c = s.c - 1;
            end
        end
        return r;
    endfunction

    function automatic int bcd_of(input int v);
        int r;
        int x;
        r = 0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r = r | ((x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        ma <= nxt(99, ma, reset_a, load_a, en_a, ud_a, int'(load_val_a));
        mb <= nxt(59, mb, reset_b, load_b, en_b, ud_b, int'(load_val_b));
    end

    always @(negedge clk) begin
        if (chk) begin
            cmp("a_count", int'(count_a), ma.c);
            cmp("a_bcd", int'(bcd_a), bcd_of(ma.c));
            cmp("a_wrap", int'(wrap_a), int'(ma.w));
            cmp("a_at_term", int'(at_term_a), int'(ud_a ? (ma.c == 99) : (ma.c == 0)));
            cmp("b_count", int'(count_b), mb.c);
            cmp("b_bcd", int'(bcd_b), bcd_of(mb.c));
            cmp("b_wrap", int'(wrap_b), int'(mb.w));
            cmp("b_at_term", int'(at_term_b), int'(ud_b ? (mb.c == 59) : (mb.c == 0)));
        end
    end

    task automatic tick_a(input bit rst, input bit ld, input bit e, input bit ud, input int lv);
        reset_a = rst; load_a = ld; en_a = e; ud_a = ud; load_val_a = 8'(lv);
        @(posedge clk);
        #2;
    endtask

    task automatic tick_b(input bit rst, input bit ld, input bit e, input bit ud, input int lv);
        reset_b = rst; load_b = ld; en_b = e; ud_b = ud; load_val_b = 6'(lv);
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset_b = 1'b1; load_b = 1'b0; en_b = 1'b0; ud_b = 1'b1; load_val_b = '0;

        // 1: reset up, full up sweep with wrap
        tick_a(1, 0, 0, 1, 0);
        chk = 1;
        cmp("rst_up_count", int'(count_a), 0);
        cmp("rst_up_bcd", int'(bcd_a), 'h00);
        cmp("rst_up_wrap", int'(wrap_a), 0);
        for (int i = 0; i < 99; i++) tick_a(0, 0, 1, 1, 0);
        cmp("pre_wrap_count", int'(count_a), 99);
        cmp("pre_wrap_bcd", int'(bcd_a), 'h99);
        cmp("pre_wrap_term", int'(at_term_a), 1);
        tick_a(0, 0, 1, 1, 0);
        cmp("wrap_up_count", int'(count_a), 0);
        cmp("wrap_up_pulse", int'(wrap_a), 1);
        tick_a(0, 0, 1, 1, 0);
        cmp("after_wrap_pulse", int'(wrap_a), 0);

        // 2: reset down, count down, load 0 then borrow-wrap
        tick_a(1, 0, 0, 0, 0);
        cmp("rst_dn_count", int'(count_a), 99);
        cmp("rst_dn_term", int'(at_term_a), 0);
        for (int i = 0; i < 3; i++) tick_a(0, 0, 1, 0, 0);
        cmp("dn3_bcd", int'(bcd_a), 'h96);
        tick_a(0, 1, 1, 0, 0);
        cmp("load0_term", int'(at_term_a), 1);
        tick_a(0, 0, 1, 0, 0);
        cmp("wrap_dn_count", int'(count_a), 99);
        cmp("wrap_dn_pulse", int'(wrap_a), 1);

        // 3: load saturation and load priority over enable
        tick_a(0, 1, 1, 1, 150);
        cmp("sat_count", int'(count_a), 99);
        cmp("sat_bcd", int'(bcd_a), 'h99);
        tick_a(0, 1, 1, 1, 40);
        cmp("load_wins", int'(count_a), 40);

        // 4: carry into tens, then borrow after a direction change
        tick_a(0, 1, 0, 1, 5);
        for (int i = 0; i < 4; i++) tick_a(0, 0, 1, 1, 0);
        cmp("nine_bcd", int'(bcd_a), 'h09);
        tick_a(0, 0, 1, 1, 0);
        cmp("carry_bcd", int'(bcd_a), 'h10);
        tick_a(0, 0, 1, 0, 0);
        cmp("borrow_bcd", int'(bcd_a), 'h09);

        // at_term follows updown without a clock edge
        tick_a(0, 1, 0, 0, 99);
        cmp("term_dn_at99", int'(at_term_a), 0);
        ud_a = 1'b1;
        #1;
        cmp("term_comb_flip", int'(at_term_a), 1);

        // 5: hold, reset priority, reset pulse between edges ignored
        tick_a(0, 1, 0, 1, 42);
        for (int i = 0; i < 5; i++) tick_a(0, 0, 0, 1, 0);
        cmp("hold_count", int'(count_a), 42);
        cmp("hold_wrap", int'(wrap_a), 0);
        tick_a(1, 1, 1, 0, 7);
        cmp("rst_wins", int'(count_a), 99);
        en_a = 1'b0; load_a = 1'b0; ud_a = 1'b1; reset_a = 1'b1;
        #1;
        reset_a = 1'b0;
        @(posedge clk);
        #2;
        cmp("async_pulse_ignored", int'(count_a), 99);

        // 6: MAX=59 instance
        tick_a(0, 0, 0, 1, 0);
        tick_b(1, 0, 0, 1, 0);
        cmp("b_rst_count", int'(count_b), 0);
        tick_b(0, 1, 0, 1, 57);
        for (int i = 0; i < 2; i++) tick_b(0, 0, 1, 1, 0);
        cmp("b_at59_bcd", int'(bcd_b), 'h59);
        tick_b(0, 0, 1, 1, 0);
        cmp("b_wrap_count", int'(count_b), 0);
        cmp("b_wrap_bcd", int'(bcd_b), 'h00);
        cmp("b_wrap_pulse", int'(wrap_b), 1);
        tick_b(0, 0, 1, 0, 0);
        cmp("b_dn_wrap_count", int'(count_b), 59);
        cmp("b_dn_wrap_pulse", int'(wrap_b), 1);
        tick_b(0, 0, 1, 0, 0);
        cmp("b_dn_58_bcd", int'(bcd_b), 'h58);
        tick_b(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
